// File: rtl/adder_io_stage.sv
// adder_io_stage: registered operand-feed and result-capture stage wrapped
// around an external combinational WIDTH-bit adder.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_valid/o_ready            operand stream handshake (i_add_term1/2)
//   o_add_term1/2              registered operands driven to the adder
//   i_sum/i_cout               adder result, combinational from o_add_term1/2
//   o_valid/i_ready            result stream handshake (o_sum/o_cout/o_mismatch)
//   o_mismatch                 captured result differs from the exact sum
//   i_clr_stats                clears counters and sticky flag
//   o_txn_count/o_err_count    saturating capture / mismatch counters
//   o_err_sticky               set on any mismatch until reset or clear
module adder_io_stage #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  output logic [WIDTH-1:0] o_add_term1,
  output logic [WIDTH-1:0] o_add_term2,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_cout,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_mismatch,
  input  logic             i_clr_stats,
  output logic [CNT_W-1:0] o_txn_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_err_sticky
);

  logic           s1_valid;
  logic           s2_load;
  logic           in_fire;
  logic           cap_mismatch;
  logic [WIDTH:0] exact_sum;

  // Stage 2 takes stage 1 when the result slot is empty or being drained.
  assign s2_load = s1_valid & (~o_valid | i_ready);
  // Depends on i_ready and state only; never on i_valid.
  assign o_ready = ~s1_valid | s2_load;
  assign in_fire = i_valid & o_ready;

  // Reference sum at WIDTH+1 bits so the carry-out is checked too.
  assign exact_sum    = {1'b0, o_add_term1} + {1'b0, o_add_term2};
  assign cap_mismatch = ({i_cout, i_sum} != exact_sum);

  // Operand register: holds its value when not loading to keep adder inputs quiet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      o_add_term1 <= '0;
      o_add_term2 <= '0;
    end else begin
      if (in_fire) begin
        s1_valid    <= 1'b1;
        o_add_term1 <= i_add_term1;
        o_add_term2 <= i_add_term2;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Result register: stable while presented and not accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_sum      <= '0;
      o_cout     <= 1'b0;
      o_mismatch <= 1'b0;
    end else begin
      if (s2_load) begin
        o_valid    <= 1'b1;
        o_sum      <= i_sum;
        o_cout     <= i_cout;
        o_mismatch <= cap_mismatch;
      end else if (i_ready & o_valid) begin
        o_valid <= 1'b0;
      end
    end
  end

  // Statistics: clear has priority over a concurrent capture.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_stats) begin
      o_txn_count  <= '0;
      o_err_count  <= '0;
      o_err_sticky <= 1'b0;
    end else if (s2_load) begin
      if (o_txn_count != {CNT_W{1'b1}}) begin
        o_txn_count <= o_txn_count + CNT_W'(1);
      end
      if (cap_mismatch) begin
        o_err_sticky <= 1'b1;
        if (o_err_count != {CNT_W{1'b1}}) begin
          o_err_count <= o_err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_io_stage.sv
module tb_adder_io_stage;

  localparam int unsigned WIDTH = 44;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic [WIDTH-1:0] o_add_term1;
  logic [WIDTH-1:0] o_add_term2;
  logic [WIDTH-1:0] i_sum;
  logic             i_cout;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_mismatch;
  logic             i_clr_stats;
  logic [CNT_W-1:0] o_txn_count;
  logic [CNT_W-1:0] o_err_count;
  logic             o_err_sticky;

  // Adder model; fault forces sum bit 20 low.
  logic           fault;
  logic [WIDTH:0] add_true;
  logic [WIDTH:0] add_out;
  assign add_true = {1'b0, o_add_term1} + {1'b0, o_add_term2};
  assign add_out  = fault ? (add_true & ~((WIDTH + 1)'(1) << 20)) : add_true;
  assign i_sum    = add_out[WIDTH-1:0];
  assign i_cout   = add_out[WIDTH];

  adder_io_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_add_term1  (i_add_term1),
    .i_add_term2  (i_add_term2),
    .o_add_term1  (o_add_term1),
    .o_add_term2  (o_add_term2),
    .i_sum        (i_sum),
    .i_cout       (i_cout),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sum        (o_sum),
    .o_cout       (o_cout),
    .o_mismatch   (o_mismatch),
    .i_clr_stats  (i_clr_stats),
    .o_txn_count  (o_txn_count),
    .o_err_count  (o_err_count),
    .o_err_sticky (o_err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected results in acceptance order plus expected stats.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             mm;
  } res_t;

  res_t exp_q[$];
  int   exp_txn = 0;
  int   exp_err = 0;

  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("stale_result", 64'(o_valid), 64'd0);
        end else begin
          res_t r;
          r = exp_q.pop_front();
          check("out_sum", 64'(o_sum), 64'(r.sum));
          check("out_cout", 64'(o_cout), 64'(r.cout));
          check("out_mismatch", 64'(o_mismatch), 64'(r.mm));
        end
      end
      if (i_valid && o_ready) begin
        longint unsigned t;
        longint unsigned f;
        res_t r;
        t = longint'(i_add_term1) + longint'(i_add_term2);
        f = fault ? (t & ~(64'd1 << 20)) : t;
        r.sum  = f[WIDTH-1:0];
        r.cout = f[WIDTH];
        r.mm   = (f != t);
        exp_q.push_back(r);
        exp_txn++;
        if (r.mm) exp_err++;
      end
    end
  end

  logic [WIDTH-1:0] pa[3];
  logic [WIDTH-1:0] pb[3];
  logic [WIDTH-1:0] held_sum;
  int               idx;
  logic             fire;

  initial begin
    i_rst       = 1'b1;
    i_valid     = 1'b0;
    i_ready     = 1'b1;
    i_add_term1 = '0;
    i_add_term2 = '0;
    i_clr_stats = 1'b0;
    fault       = 1'b0;
    step();
    step();
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_ready", 64'(o_ready), 64'd1);
    check("rst_term1", 64'(o_add_term1), 64'd0);
    check("rst_sum", 64'(o_sum), 64'd0);
    check("rst_cout", 64'(o_cout), 64'd0);
    check("rst_mismatch", 64'(o_mismatch), 64'd0);
    check("rst_txn", 64'(o_txn_count), 64'd0);
    check("rst_err", 64'(o_err_count), 64'd0);
    check("rst_sticky", 64'(o_err_sticky), 64'd0);
    i_rst = 1'b0;
    step();

    // Single pair 1 + 2.
    i_valid     = 1'b1;
    i_add_term1 = 44'h000_0000_0001;
    i_add_term2 = 44'h000_0000_0002;
    check("single_ready", 64'(o_ready), 64'd1);
    step();
    i_valid = 1'b0;
    check("single_ready_after", 64'(o_ready), 64'd1);
    check("single_not_yet", 64'(o_valid), 64'd0);
    step();
    check("single_valid", 64'(o_valid), 64'd1);
    check("single_sum", 64'(o_sum), 64'h3);
    check("single_cout", 64'(o_cout), 64'd0);
    check("single_mm", 64'(o_mismatch), 64'd0);
    check("single_txn", 64'(o_txn_count), 64'd1);

    // Carry wrap.
    i_valid     = 1'b1;
    i_add_term1 = 44'hFFF_FFFF_FFFF;
    i_add_term2 = 44'h000_0000_0001;
    step();
    i_valid = 1'b0;
    step();
    check("wrap_valid", 64'(o_valid), 64'd1);
    check("wrap_sum", 64'(o_sum), 64'd0);
    check("wrap_cout", 64'(o_cout), 64'd1);
    check("wrap_mm", 64'(o_mismatch), 64'd0);
    check("wrap_txn", 64'(o_txn_count), 64'd2);
    check("hold_term1", 64'(o_add_term1), 64'hFFF_FFFF_FFFF);
    step();

    // Streaming 100 random pairs at full rate.
    for (int i = 0; i < 100; i++) begin
      i_valid     = 1'b1;
      i_add_term1 = WIDTH'({$urandom(), $urandom()});
      i_add_term2 = WIDTH'({$urandom(), $urandom()});
      check("stream_ready", 64'(o_ready), 64'd1);
      step();
      if (i >= 1) check("stream_valid", 64'(o_valid), 64'd1);
    end
    i_valid = 1'b0;
    repeat (4) step();
    check("stream_drained", 64'(exp_q.size()), 64'd0);
    check("stream_txn", 64'(o_txn_count), 64'(exp_txn));

    // Backpressure: 3 pairs offered over 5 cycles with i_ready low.
    for (int k = 0; k < 3; k++) begin
      pa[k] = WIDTH'({$urandom(), $urandom()});
      pb[k] = WIDTH'({$urandom(), $urandom()});
    end
    held_sum = pa[0] + pb[0];
    i_ready  = 1'b0;
    idx      = 0;
    for (int k = 0; k < 5; k++) begin
      i_valid     = 1'b1;
      i_add_term1 = pa[idx];
      i_add_term2 = pb[idx];
      fire        = o_ready;
      step();
      if (fire) idx++;
      if (k >= 1) begin
        check("bp_valid", 64'(o_valid), 64'd1);
        check("bp_sum_stable", 64'(o_sum), 64'(held_sum));
      end
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_ready_low", 64'(o_ready), 64'd0);
    i_ready = 1'b1;
    for (int t = 0; t < 10 && idx < 3; t++) begin
      i_add_term1 = pa[idx];
      i_add_term2 = pb[idx];
      fire        = o_ready;
      step();
      if (fire) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'd3);
    i_valid = 1'b0;
    repeat (4) step();
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_txn", 64'(o_txn_count), 64'(exp_txn));

    // Fault injection on sum bit 20.
    fault       = 1'b1;
    i_valid     = 1'b1;
    i_add_term1 = 44'h000_0008_0000;
    i_add_term2 = 44'h000_0008_0000;
    step();
    i_valid = 1'b0;
    step();
    check("fault_valid", 64'(o_valid), 64'd1);
    check("fault_sum", 64'(o_sum), 64'd0);
    check("fault_mm", 64'(o_mismatch), 64'd1);
    check("fault_err", 64'(o_err_count), 64'd1);
    check("fault_err_model", 64'(o_err_count), 64'(exp_err));
    check("fault_sticky", 64'(o_err_sticky), 64'd1);
    check("fault_txn", 64'(o_txn_count), 64'(exp_txn));
    step();
    // Clear coinciding with the next capture.
    i_valid     = 1'b1;
    i_add_term1 = 44'h000_0000_0001;
    i_add_term2 = 44'h000_0000_0001;
    step();
    i_valid     = 1'b0;
    i_clr_stats = 1'b1;
    step();
    i_clr_stats = 1'b0;
    exp_txn     = 0;
    exp_err     = 0;
    check("clr_valid", 64'(o_valid), 64'd1);
    check("clr_sum", 64'(o_sum), 64'd2);
    check("clr_txn", 64'(o_txn_count), 64'd0);
    check("clr_err", 64'(o_err_count), 64'd0);
    check("clr_sticky", 64'(o_err_sticky), 64'd0);
    step();
    step();
    check("clr_txn_after", 64'(o_txn_count), 64'd0);
    fault = 1'b0;

    // Reset with both stages full.
    i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_valid     = 1'b1;
      i_add_term1 = WIDTH'({$urandom(), $urandom()});
      i_add_term2 = WIDTH'({$urandom(), $urandom()});
      step();
    end
    i_valid = 1'b0;
    check("full_ready_low", 64'(o_ready), 64'd0);
    check("full_txn", 64'(o_txn_count), 64'd1);
    i_rst = 1'b1;
    step();
    check("rst2_valid", 64'(o_valid), 64'd0);
    check("rst2_ready", 64'(o_ready), 64'd1);
    check("rst2_txn", 64'(o_txn_count), 64'd0);
    check("rst2_err", 64'(o_err_count), 64'd0);
    i_rst = 1'b0;
    exp_q.delete();
    exp_txn = 0;
    exp_err = 0;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rst2_no_stale", 64'(o_valid), 64'd0);
    end
    check("rst2_txn_after", 64'(o_txn_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
